mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single byte-addressed data memory port between instruction fetch (IF) and the MEM-stage load/store unit (DM).
//   Registered arbiter + access sequencer: latches the winner's request, drives the memory port for 1+WAIT_STATES cycles, returns one valid pulse.
//   Sits between the pipeline stages and data_mem; the pipeline stalls a requester until its valid pulse.
// PARAMETERS
//   WAIT_STATES   1   extra ACCESS cycles per transaction (0..7); models slower memory
//   STARVE_LIMIT  4   consecutive conflict losses by IF before IF is forced to win (1..15)
// PORTS
//   clk              in   1   system clock, rising edge
//   rst_i            in   1   asynchronous, active-high reset
//   if_req_i         in   1   fetch request; held with if_addr_i until if_valid_o
//   if_addr_i        in   8   fetch byte address (always LW)
//   if_valid_o       out  1   one-cycle pulse: if_rdata_o valid, fetch complete
//   if_rdata_o       out  32  fetched word
//   dm_req_i         in   1   data request; held with payload until dm_valid_o
//   dm_we_i          in   1   1=store, 0=load
//   dm_addr_i        in   8   data byte address
//   dm_wdata_i       in   32  store data
//   dm_load_type_i   in   3   LOAD_B/BU/H/HU/W code, passed through
//   dm_store_type_i  in   2   STORE_B/H/W code, passed through
//   dm_valid_o       out  1   one-cycle pulse: load data valid / store committed
//   dm_rdata_o       out  32  load data
//   mem_rd_en_o      out  1   to data_mem rd_en_i
//   mem_wr_en_o      out  1   to data_mem wr_en_i
//   mem_addr_o       out  8   to data_mem addr_i
//   mem_wr_data_o    out  32  to data_mem wr_data_i
//   mem_load_type_o  out  3   to data_mem load_type_i (LOAD_W for fetch)
//   mem_store_type_o out  2   to data_mem store_type_i
//   mem_rd_data_i    in   32  from data_mem rd_data_o (combinational read)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, starve_cnt=0, wait_cnt=0; all outputs 0 incl. mem_wr_en_o.
//   FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: no req -> stay. Any req -> pick winner, latch addr/we/wdata/types/owner, wait_cnt=WAIT_STATES, go ACCESS.
//   Arbitration: DM only or IF only -> that one. Both: DM wins unless starve_cnt==STARVE_LIMIT, then IF wins.
//   starve_cnt: +1 when both req and DM wins; cleared to 0 whenever IF is granted; never exceeds STARVE_LIMIT.
//   ACCESS: mem_addr_o/types/wr_data from latched regs; loads/fetch: mem_rd_en_o=1 all ACCESS cycles.
//     wait_cnt>0 -> decrement, stay. wait_cnt==0 -> last cycle: read captures mem_rd_data_i into owner's rdata reg;
//     store asserts mem_wr_en_o for this cycle only (write lands on this edge); go DONE.
//   DONE: owner's valid_o=1 exactly one cycle; mem_* enables 0; go IDLE. Requests are not sampled in DONE
//     (requester drops/changes req after seeing valid).
//   Latency: req seen in IDLE cycle N -> valid in cycle N+2+WAIT_STATES; throughput one txn per 3+WAIT_STATES cycles.
//   rdata regs hold last value until next completion of same owner; stores leave dm_rdata_o unchanged.
//   Fetch always forces mem_load_type_o=LOAD_W, mem_wr_en_o=0 regardless of dm_* inputs.
//   Addresses pass unmodified; addr+1..+3 wrap mod 256 inside data_mem; no alignment checks.
//   Request dropped mid-transaction: ignored, transaction still completes and pulses valid.
//   Reset mid-ACCESS: store is aborted (mem_wr_en_o drops asynchronously), no valid pulse, starve_cnt cleared.
// CONFIGURATION
//   MEM_ARB_PERF_EN defined: adds ports perf_conflict_o (out,16: cycles in IDLE with both reqs high) and
//     perf_if_stall_o (out,16: cycles if_req_i high without IF owning a txn); both saturate at 16'hFFFF, reset to 0.
//   Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//   WAIT_STATES=1; IF-only req addr 8'h10, mem word 32'h00A00093 -> if_valid_o at cycle N+3, if_rdata_o=32'h00A00093.
//   DM SW addr 8'hFC data 32'hDEADBEEF, then DM LW 8'hFC -> mem_wr_en_o high one cycle; load returns 32'hDEADBEEF.
//   DM LB at byte holding 8'h80 -> dm_rdata_o=32'hFFFFFF80; LBU -> 32'h00000080.
//   IF and DM held high continuously, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF repeating; starve_cnt never >4.
//   Assert rst_i mid-ACCESS of SW to 8'h20 -> mem_wr_en_o low at once, mem[8'h20..23] unchanged, no dm_valid_o.
//   MEM_ARB_PERF_EN, 10 cycles both reqs contending -> perf_conflict_o equals IDLE-cycles-with-both count; saturates, no wrap.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares the single byte-addressed data memory port between instruction
//   fetch (IF) and the MEM-stage load/store unit (DM). The winning request is
//   latched in IDLE. The memory port is then driven for 1+WAIT_STATES ACCESS
//   cycles. Finally a one-cycle valid pulse is returned to the owner in DONE.
//   A requester holds its request and payload until it sees its valid pulse.
//
// Parameters:
//   WAIT_STATES   extra ACCESS cycles per transaction (0..7)
//   STARVE_LIMIT  consecutive conflict losses by IF before IF is forced to
//                 win (1..15)
//
// Ports:
//   clk, rst_i                  clock (rising edge), async active-high reset
//   if_req_i, if_addr_i         fetch request (always a word load)
//   if_valid_o, if_rdata_o      fetch completion pulse and fetched word
//   dm_req_i, dm_we_i,
//   dm_addr_i, dm_wdata_i,
//   dm_load_type_i,
//   dm_store_type_i             load/store request and payload
//   dm_valid_o, dm_rdata_o      load/store completion pulse and load data
//   mem_rd_en_o, mem_wr_en_o,
//   mem_addr_o, mem_wr_data_o,
//   mem_load_type_o,
//   mem_store_type_o            drive data_mem
//   mem_rd_data_i               data_mem combinational read data
//
// Optional feature (macro MEM_ARB_PERF_EN):
//   perf_conflict_o  cycles spent in IDLE with both requests high
//   perf_if_stall_o  cycles with if_req_i high while IF does not own a
//                    transaction
//   Both counters saturate at 16'hFFFF and reset to 0. Without the macro the
//   ports and counters do not exist.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [7:0]  if_addr_i,
    output logic        if_valid_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [7:0]  dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [2:0]  dm_load_type_i,
    input  logic [1:0]  dm_store_type_i,
    output logic        dm_valid_o,
    output logic [31:0] dm_rdata_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [7:0]  mem_addr_o,
    output logic [31:0] mem_wr_data_o,
    output logic [2:0]  mem_load_type_o,
    output logic [1:0]  mem_store_type_o,
    input  logic [31:0] mem_rd_data_i
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0] perf_conflict_o,
    output logic [15:0] perf_if_stall_o
`endif
);

    // Load-type code for a full word; fetches always use it.
    localparam logic [2:0] LOAD_W     = 3'b010;
    localparam logic [2:0] WAIT_INIT  = 3'(WAIT_STATES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [2:0]  wait_cnt_reg;
    logic [3:0]  starve_cnt_reg;
    logic        owner_if_reg;
    logic        we_reg;

    logic        if_valid_reg;
    logic        dm_valid_reg;
    logic [31:0] if_rdata_reg;
    logic [31:0] dm_rdata_reg;
    logic        mem_rd_en_reg;
    logic        mem_wr_en_reg;
    logic [7:0]  mem_addr_reg;
    logic [31:0] mem_wr_data_reg;
    logic [2:0]  mem_load_type_reg;
    logic [1:0]  mem_store_type_reg;

    // Arbitration. DM normally wins a conflict. Once IF has lost STARVE_LIMIT
    // conflicts in a row it is given the port instead.
    logic both_req;
    logic grant_if;
    logic grant_store;

    assign both_req    = if_req_i && dm_req_i;
    assign grant_if    = if_req_i && (!dm_req_i || (starve_cnt_reg == STARVE_MAX));
    assign grant_store = !grant_if && dm_we_i;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_reg          <= ST_IDLE;
            wait_cnt_reg       <= '0;
            starve_cnt_reg     <= '0;
            owner_if_reg       <= 1'b0;
            we_reg             <= 1'b0;
            if_valid_reg       <= 1'b0;
            dm_valid_reg       <= 1'b0;
            if_rdata_reg       <= '0;
            dm_rdata_reg       <= '0;
            mem_rd_en_reg      <= 1'b0;
            mem_wr_en_reg      <= 1'b0;
            mem_addr_reg       <= '0;
            mem_wr_data_reg    <= '0;
            mem_load_type_reg  <= '0;
            mem_store_type_reg <= '0;
        end else begin
            // Valid pulses last exactly one cycle (the DONE cycle).
            if_valid_reg <= 1'b0;
            dm_valid_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (if_req_i || dm_req_i) begin
                        owner_if_reg <= grant_if;
                        if (grant_if) begin
                            we_reg             <= 1'b0;
                            mem_addr_reg       <= if_addr_i;
                            mem_wr_data_reg    <= '0;
                            mem_load_type_reg  <= LOAD_W;
                            mem_store_type_reg <= '0;
                            starve_cnt_reg     <= '0;
                        end else begin
                            we_reg             <= dm_we_i;
                            mem_addr_reg       <= dm_addr_i;
                            mem_wr_data_reg    <= dm_wdata_i;
                            mem_load_type_reg  <= dm_load_type_i;
                            mem_store_type_reg <= dm_store_type_i;
                            // Cannot exceed STARVE_MAX: at the limit IF wins.
                            if (both_req) begin
                                starve_cnt_reg <= starve_cnt_reg + 4'd1;
                            end
                        end
                        // Read enable covers every ACCESS cycle. The write
                        // enable is raised only in the final ACCESS cycle,
                        // which is the first cycle when there are no waits.
                        mem_rd_en_reg <= !grant_store;
                        mem_wr_en_reg <= grant_store && (WAIT_STATES == 0);
                        wait_cnt_reg  <= WAIT_INIT;
                        state_reg     <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (wait_cnt_reg != 3'd0) begin
                        wait_cnt_reg  <= wait_cnt_reg - 3'd1;
                        // The next cycle is the final ACCESS cycle.
                        mem_wr_en_reg <= we_reg && (wait_cnt_reg == 3'd1);
                    end else begin
                        // Final ACCESS cycle. A store lands on this edge; a
                        // read captures the memory's combinational data.
                        mem_rd_en_reg <= 1'b0;
                        mem_wr_en_reg <= 1'b0;
                        if (!we_reg) begin
                            if (owner_if_reg) begin
                                if_rdata_reg <= mem_rd_data_i;
                            end else begin
                                dm_rdata_reg <= mem_rd_data_i;
                            end
                        end
                        if (owner_if_reg) begin
                            if_valid_reg <= 1'b1;
                        end else begin
                            dm_valid_reg <= 1'b1;
                        end
                        state_reg <= ST_DONE;
                    end
                end

                // Requests are deliberately not sampled here. The requester
                // updates its request after seeing its valid pulse.
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_valid_o       = if_valid_reg;
    assign if_rdata_o       = if_rdata_reg;
    assign dm_valid_o       = dm_valid_reg;
    assign dm_rdata_o       = dm_rdata_reg;
    assign mem_rd_en_o      = mem_rd_en_reg;
    assign mem_wr_en_o      = mem_wr_en_reg;
    assign mem_addr_o       = mem_addr_reg;
    assign mem_wr_data_o    = mem_wr_data_reg;
    assign mem_load_type_o  = mem_load_type_reg;
    assign mem_store_type_o = mem_store_type_reg;

`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_conflict_reg;
    logic [15:0] perf_if_stall_reg;
    logic        if_owns_txn;

    // IF owns the port from its ACCESS cycles through its DONE cycle.
    assign if_owns_txn = (state_reg != ST_IDLE) && owner_if_reg;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            perf_conflict_reg <= '0;
            perf_if_stall_reg <= '0;
        end else begin
            if ((state_reg == ST_IDLE) && both_req && (perf_conflict_reg != 16'hFFFF)) begin
                perf_conflict_reg <= perf_conflict_reg + 16'd1;
            end
            if (if_req_i && !if_owns_txn && (perf_if_stall_reg != 16'hFFFF)) begin
                perf_if_stall_reg <= perf_if_stall_reg + 16'd1;
            end
        end
    end

    assign perf_conflict_o = perf_conflict_reg;
    assign perf_if_stall_o = perf_if_stall_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Checks mem_port_arbiter (WAIT_STATES=1, STARVE_LIMIT=4) against a
// transaction-level reference model.
//
// For every request sampled while the port is free, the model decides the
// winner from the starvation rule. It then schedules the access window and
// the completion cycle as plain cycle offsets from the sampling cycle. A
// separate reference memory resolves load data. The bench also acts as
// data_mem for the DUT.
//
// Directed cases use hand-computed literals. Random traffic from two
// requester agents fills the rest.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int WS = 1;
    localparam int SL = 4;

    localparam logic [2:0] LT_B  = 3'b000;
    localparam logic [2:0] LT_H  = 3'b001;
    localparam logic [2:0] LT_W  = 3'b010;
    localparam logic [2:0] LT_BU = 3'b100;
    localparam logic [2:0] LT_HU = 3'b101;
    localparam logic [1:0] SS_B  = 2'b00;
    localparam logic [1:0] SS_H  = 2'b01;
    localparam logic [1:0] SS_W  = 2'b10;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [7:0]  if_addr_i;
    logic        if_valid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [7:0]  dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [2:0]  dm_load_type_i;
    logic [1:0]  dm_store_type_i;
    logic        dm_valid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wr_data_o;
    logic [2:0]  mem_load_type_o;
    logic [1:0]  mem_store_type_o;
    logic [31:0] mem_rd_data;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_conflict_o;
    logic [15:0] perf_if_stall_o;
`endif

    mem_port_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(SL)) dut (
        .clk              (clk),
        .rst_i            (rst_i),
        .if_req_i         (if_req_i),
        .if_addr_i        (if_addr_i),
        .if_valid_o       (if_valid_o),
        .if_rdata_o       (if_rdata_o),
        .dm_req_i         (dm_req_i),
        .dm_we_i          (dm_we_i),
        .dm_addr_i        (dm_addr_i),
        .dm_wdata_i       (dm_wdata_i),
        .dm_load_type_i   (dm_load_type_i),
        .dm_store_type_i  (dm_store_type_i),
        .dm_valid_o       (dm_valid_o),
        .dm_rdata_o       (dm_rdata_o),
        .mem_rd_en_o      (mem_rd_en_o),
        .mem_wr_en_o      (mem_wr_en_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wr_data_o    (mem_wr_data_o),
        .mem_load_type_o  (mem_load_type_o),
        .mem_store_type_o (mem_store_type_o),
        .mem_rd_data_i    (mem_rd_data)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_conflict_o  (perf_conflict_o),
        .perf_if_stall_o  (perf_if_stall_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] load_ext(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input logic [2:0] lt);
        case (lt)
            LT_B:    return {{24{b0[7]}}, b0};
            LT_H:    return {{16{b1[7]}}, b1, b0};
            LT_BU:   return {24'd0, b0};
            LT_HU:   return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 73 + 29) ^ (i >> 3));
    endfunction

    // Poke requests are applied by the memory processes (env at posedge,
    // reference at negedge).
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;

    // ---------------- data_mem stand-in (DUT side) ----------------
    logic [7:0] env_mem [256];
    logic [7:0] rd_a1, rd_a2, rd_a3;

    always_comb begin
        rd_a1 = mem_addr_o + 8'd1;
        rd_a2 = mem_addr_o + 8'd2;
        rd_a3 = mem_addr_o + 8'd3;
        mem_rd_data = load_ext(env_mem[mem_addr_o], env_mem[rd_a1], env_mem[rd_a2],
                               env_mem[rd_a3], mem_load_type_o);
    end

    initial begin : env_proc
        logic [7:0] a;
        for (int i = 0; i < 256; i++) env_mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_wr_en_o) begin
                a = mem_addr_o;
                env_mem[a] = mem_wr_data_o[7:0];
                if (mem_store_type_o != SS_B) env_mem[a + 8'd1] = mem_wr_data_o[15:8];
                if (mem_store_type_o == SS_W) begin
                    env_mem[a + 8'd2] = mem_wr_data_o[23:16];
                    env_mem[a + 8'd3] = mem_wr_data_o[31:24];
                end
            end
            if (poke_en) begin
                for (int k = 0; k < 4; k++) env_mem[poke_addr + 8'(k)] = poke_data[8*k +: 8];
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic [7:0]  ref_mem [256];
    bit          chk_en = 1'b0;
    bit          m_init = 1'b1;
    bit          t_act, t_if, t_we;
    logic [7:0]  t_addr;
    logic [31:0] t_wd, t_rd;
    logic [2:0]  t_lt;
    logic [1:0]  t_st;
    int          t_start, free_at, starve, d;
    logic [31:0] exp_if_rd, exp_dm_rd;
    bit          e_ifv, e_dmv, e_rd, e_wr, in_acc;
    int          completions = 0;
    int          wr_seen = 0;

    initial begin : model_proc
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        forever begin
            @(negedge clk);
            if (poke_en) begin
                for (int k = 0; k < 4; k++) ref_mem[poke_addr + 8'(k)] = poke_data[8*k +: 8];
            end
            if (mem_wr_en_o) wr_seen++;
            if (!chk_en) begin
                m_init = 1'b1;
            end else begin
                if (m_init) begin
                    m_init    = 1'b0;
                    t_act     = 1'b0;
                    free_at   = cyc;
                    starve    = 0;
                    exp_if_rd = '0;
                    exp_dm_rd = '0;
                end
                e_ifv = 0; e_dmv = 0; e_rd = 0; e_wr = 0; in_acc = 0; d = -1;
                if (t_act) begin
                    d = cyc - t_start;
                    if (d >= 1 && d <= 1 + WS) begin
                        in_acc = 1;
                        e_rd   = !t_we;
                        e_wr   = t_we && (d == 1 + WS);
                    end
                    if (d == 1 + WS && !t_we) begin
                        t_rd = load_ext(ref_mem[t_addr], ref_mem[t_addr + 8'd1],
                                        ref_mem[t_addr + 8'd2], ref_mem[t_addr + 8'd3],
                                        t_if ? LT_W : t_lt);
                    end
                    if (d == 2 + WS) begin
                        if (t_if) begin
                            e_ifv = 1; exp_if_rd = t_rd;
                        end else begin
                            e_dmv = 1;
                            if (!t_we) exp_dm_rd = t_rd;
                        end
                    end
                end
                check("if_valid", 32'(if_valid_o), 32'(e_ifv));
                check("dm_valid", 32'(dm_valid_o), 32'(e_dmv));
                check("mem_rd_en", 32'(mem_rd_en_o), 32'(e_rd));
                check("mem_wr_en", 32'(mem_wr_en_o), 32'(e_wr));
                check("if_rdata", if_rdata_o, exp_if_rd);
                check("dm_rdata", dm_rdata_o, exp_dm_rd);
                if (in_acc) begin
                    check("mem_addr", 32'(mem_addr_o), 32'(t_addr));
                    check("mem_load_type", 32'(mem_load_type_o), 32'(t_if ? LT_W : t_lt));
                    if (t_we) begin
                        check("mem_wr_data", mem_wr_data_o, t_wd);
                        check("mem_store_type", 32'(mem_store_type_o), 32'(t_st));
                    end
                end
                if (t_act && d == 1 + WS && t_we) begin
                    ref_mem[t_addr] = t_wd[7:0];
                    if (t_st != SS_B) ref_mem[t_addr + 8'd1] = t_wd[15:8];
                    if (t_st == SS_W) begin
                        ref_mem[t_addr + 8'd2] = t_wd[23:16];
                        ref_mem[t_addr + 8'd3] = t_wd[31:24];
                    end
                end
                if (t_act && d == 2 + WS) begin
                    t_act = 1'b0;
                    completions++;
                end
                // Port free: sample requests and pick a winner.
                if (!t_act && cyc >= free_at && (if_req_i || dm_req_i)) begin
                    if (if_req_i && dm_req_i) begin
                        if (starve == SL) begin
                            t_if = 1; starve = 0;
                        end else begin
                            t_if = 0; starve++;
                        end
                    end else if (if_req_i) begin
                        t_if = 1; starve = 0;
                    end else begin
                        t_if = 0;
                    end
                    if (t_if) begin
                        t_we = 0; t_addr = if_addr_i;
                    end else begin
                        t_we = dm_we_i; t_addr = dm_addr_i; t_wd = dm_wdata_i;
                        t_lt = dm_load_type_i; t_st = dm_store_type_i;
                    end
                    t_act   = 1'b1;
                    t_start = cyc;
                    free_at = cyc + 3 + WS;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic poke(input logic [7:0] a, input logic [31:0] w);
        poke_addr = a; poke_data = w; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic txn(input bit is_if, input bit we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [2:0] lt, input logic [1:0] st,
                       output logic [31:0] rd, output int lat);
        bit got;
        got = 0; lat = -1; rd = '0;
        if (is_if) begin
            if_req_i = 1; if_addr_i = addr;
        end else begin
            dm_req_i = 1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wd;
            dm_load_type_i = lt; dm_store_type_i = st;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (is_if ? if_valid_o : dm_valid_o) begin
                got = 1; lat = k; rd = is_if ? if_rdata_o : dm_rdata_o;
            end
            @(posedge clk); #1;
        end
        if (is_if) if_req_i = 0; else dm_req_i = 0;
        check("txn_completed", 32'(got), 32'd1);
    endtask

    task automatic run_random(input int ncyc);
        logic [2:0] lts [5];
        bit ifv, dmv, drained;
        lts = '{LT_B, LT_H, LT_W, LT_BU, LT_HU};
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk); ifv = if_valid_o; dmv = dm_valid_o;
            @(posedge clk); #1;
            if (ifv) if_req_i = 0;
            if (dmv) dm_req_i = 0;
            if (!if_req_i && $urandom_range(0, 2) == 0) begin
                if_req_i = 1; if_addr_i = 8'($urandom);
            end
            if (!dm_req_i && $urandom_range(0, 2) == 0) begin
                dm_req_i = 1; dm_we_i = 1'($urandom); dm_addr_i = 8'($urandom);
                dm_wdata_i = $urandom; dm_load_type_i = lts[$urandom_range(0, 4)];
                dm_store_type_i = 2'($urandom_range(0, 2));
            end
        end
        drained = !if_req_i && !dm_req_i;
        for (int k = 0; k < 40 && !drained; k++) begin
            @(negedge clk); ifv = if_valid_o; dmv = dm_valid_o;
            @(posedge clk); #1;
            if (ifv) if_req_i = 0;
            if (dmv) dm_req_i = 0;
            drained = !if_req_i && !dm_req_i;
        end
        if_req_i = 0; dm_req_i = 0;
        check("random_drained", 32'(drained), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main_proc
        logic [31:0] rd;
        int lat, wb, ng, nv;
        bit found;
        bit seq [10];

        rst_i = 1; if_req_i = 0; if_addr_i = '0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = '0; dm_wdata_i = '0; dm_load_type_i = '0; dm_store_type_i = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_if_valid", 32'(if_valid_o), 32'd0);
        check("reset_dm_valid", 32'(dm_valid_o), 32'd0);
        check("reset_rd_en", 32'(mem_rd_en_o), 32'd0);
        check("reset_wr_en", 32'(mem_wr_en_o), 32'd0);
        check("reset_if_rdata", if_rdata_o, 32'd0);
        check("reset_dm_rdata", dm_rdata_o, 32'd0);
        check("reset_mem_addr", 32'(mem_addr_o), 32'd0);
        @(posedge clk); #1;
        rst_i = 0; chk_en = 1;

        // Fetch: valid three cycles after the request is seen.
        poke(8'h10, 32'h00A00093);
        txn(1, 0, 8'h10, '0, LT_W, SS_W, rd, lat);
        check("fetch_rdata", rd, 32'h00A00093);
        check("fetch_latency", 32'(lat), 32'd3);

        // Both requesters held high continuously.
        if_req_i = 1; if_addr_i = 8'h10;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 8'h40; dm_load_type_i = LT_W;
        ng = 0;
        for (int k = 0; k < 80 && ng < 10; k++) begin
            @(negedge clk);
            if (if_valid_o && ng < 10) begin seq[ng] = 1; ng++; end
            if (dm_valid_o && ng < 10) begin seq[ng] = 0; ng++; end
            @(posedge clk); #1;
        end
        if_req_i = 0; dm_req_i = 0;
        check("contention_grants", 32'(ng), 32'd10);
        for (int i = 0; i < 10; i++) check("grant_order", 32'(seq[i]), 32'((i % 5) == 4));
        repeat (2) @(posedge clk); #1;

        // Store word, then load it back.
        wb = wr_seen;
        txn(0, 1, 8'hFC, 32'hDEADBEEF, LT_W, SS_W, rd, lat);
        check("sw_wr_en_cycles", 32'(wr_seen - wb), 32'd1);
        check("sw_latency", 32'(lat), 32'd3);
        txn(0, 0, 8'hFC, '0, LT_W, SS_W, rd, lat);
        check("lw_rdata", rd, 32'hDEADBEEF);

        // Byte loads with and without sign extension.
        poke(8'h40, 32'h00008000);
        txn(0, 0, 8'h41, '0, LT_B, SS_W, rd, lat);
        check("lb_rdata", rd, 32'hFFFFFF80);
        txn(0, 0, 8'h41, '0, LT_BU, SS_W, rd, lat);
        check("lbu_rdata", rd, 32'h00000080);

        run_random(600);

        // Reset during the write cycle of a store.
        chk_en = 0;
        poke(8'h20, 32'h44332211);
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 8'h20; dm_wdata_i = 32'hCAFEF00D;
        dm_store_type_i = SS_W; dm_load_type_i = LT_W;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (mem_wr_en_o) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("rst_store_reached", 32'(found), 32'd1);
        #2; rst_i = 1; #1;
        check("rst_wr_en_drop", 32'(mem_wr_en_o), 32'd0);
        check("rst_rd_en_drop", 32'(mem_rd_en_o), 32'd0);
        dm_req_i = 0;
        @(posedge clk); #1;
        rst_i = 0;
        nv = 0;
        repeat (6) begin @(negedge clk); if (dm_valid_o) nv++; end
        check("rst_no_valid", 32'(nv), 32'd0);
        check("rst_mem_unchanged", {env_mem[8'h23], env_mem[8'h22], env_mem[8'h21], env_mem[8'h20]},
              32'h44332211);
        @(posedge clk); #1;
        chk_en = 1;

        run_random(300);
        check("progress", 32'(completions > 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
